// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    // Number of memory beats needed to move one requester word.
    function automatic int calc_beats(input int data_width, input int store_width);
        return data_width / store_width;
    endfunction

    localparam int BEATS = calc_beats(32, 8);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic r_last;
    logic w_idx;

    // On a tie the port that did not win last time goes first; reset value 1 favours port 0.
    always_comb begin
        w_idx = 1'b0;
        case (req_i)
            2'b01:   w_idx = 1'b0;
            2'b10:   w_idx = 1'b1;
            2'b11:   w_idx = ~r_last;
            default: w_idx = 1'b0;
        endcase
    end

    assign idx_o = w_idx;
    assign gnt_o = (req_i == 2'b00) ? 2'b00 : (w_idx ? 2'b10 : 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (accept_i && (req_i != 2'b00)) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates two requesters onto a byte-wide memory port and
// serialises each access into little-endian beats.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STORE_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_i,
    input  logic [1:0]               we_i,
    input  logic [1:0]               addr_mode_i,
    input  logic [ADDRESS_WIDTH-1:0] addr0_i,
    input  logic [ADDRESS_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0]    wdata0_i,
    input  logic [DATA_WIDTH-1:0]    wdata1_i,
    output logic [1:0]               ready_o,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic                     busy_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_a_o,
    output logic [STORE_WIDTH-1:0]   mem_wd_o,
    input  logic [STORE_WIDTH-1:0]   mem_rd_i,
    output state_e                   state_o
);

    localparam int NBEATS = calc_beats(DATA_WIDTH, STORE_WIDTH);
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_WORD_BEAT = CW'(NBEATS - 1);

    // Handshake: a requester holds req_i[p] high with stable fields until ready_o[p]
    // pulses for one cycle; fields are sampled only in IDLE, and a request still high
    // in the IDLE after that pulse starts a new transaction.

    state_e                   r_state;
    logic                     r_port;
    logic                     r_we;
    logic                     r_mode;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic [CW-1:0]            r_beat;

    logic [1:0]               w_gnt;
    logic                     w_idx;
    logic                     w_accept;
    logic                     w_last_beat;
    logic                     w_xfer;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .accept_i (w_accept),
        .gnt_o    (w_gnt),
        .idx_o    (w_idx)
    );

    assign w_accept    = (r_state == IDLE) && (w_gnt != 2'b00);
    assign w_last_beat = r_mode ? (r_beat == '0) : (r_beat == LAST_WORD_BEAT);
    assign w_xfer      = (r_state == XFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_mode  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port  <= w_idx;
                        r_we    <= we_i[w_idx];
                        r_mode  <= addr_mode_i[w_idx];
                        r_addr  <= w_idx ? addr1_i : addr0_i;
                        r_wdata <= w_idx ? wdata1_i : wdata0_i;
                        // Cleared so a byte load comes back zero-extended.
                        r_rdata <= '0;
                        r_beat  <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (!r_we) begin
                        r_rdata[int'(r_beat)*STORE_WIDTH +: STORE_WIDTH] <= mem_rd_i;
                    end
                    if (w_last_beat) begin
                        r_state <= DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_we_o = w_xfer && r_we;
    assign mem_a_o  = w_xfer ? (r_addr + ADDRESS_WIDTH'(r_beat)) : '0;
    assign mem_wd_o = w_xfer ? r_wdata[int'(r_beat)*STORE_WIDTH +: STORE_WIDTH] : '0;

    assign ready_o  = (r_state == DONE) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o  = r_rdata;
    assign busy_o   = (r_state != IDLE);
    assign state_o  = r_state;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the pipelined RISC-V core. It shares one byte-wide data-memory port between two requesters: port 0 (CPU load/store unit, MEM stage) and port 1 (program/data loader or debug master). It arbitrates round-robin and serialises each word access into single-byte memory beats, little-endian. It presents a req/ready handshake upstream and drives the byte-wide memory array downstream.

## Interface
- `ADDRESS_WIDTH`, default 32: address width, both sides.
- `DATA_WIDTH`, default 32: requester data width.
- `STORE_WIDTH`, default 8: memory beat width. `BEATS = DATA_WIDTH/STORE_WIDTH` (4).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_i` in [1:0]: per-port request, held high until that port's `ready_o`.
- `we_i` in [1:0]: per-port write enable (1 = store, 0 = load).
- `addr_mode_i` in [1:0]: per-port mode (1 = byte, 1 beat; 0 = word, BEATS beats).
- `addr0_i`, `addr1_i` in ADDRESS_WIDTH: per-port byte address.
- `wdata0_i`, `wdata1_i` in DATA_WIDTH: per-port store data.
- `ready_o` out [1:0]: one-cycle completion pulse, one-hot or zero.
- `rdata_o` out DATA_WIDTH: load result. Valid only while a `ready_o` bit is high.
- `busy_o` out 1: high in any state other than IDLE.
- `mem_we_o` out 1: memory byte write strobe.
- `mem_a_o` out ADDRESS_WIDTH: memory byte address.
- `mem_wd_o` out STORE_WIDTH: memory write byte.
- `mem_rd_i` in STORE_WIDTH: memory read byte (combinational from `mem_a_o`).

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - If any `req_i` bit is set, the arbiter picks a winner.
  - Latch the winner's index, `we`, mode, address and wdata; clear the beat counter; go to XFER.
  - If no request, stay in IDLE.
- Arbitration: 2-way round-robin. The last-grant pointer resets to 1, so port 0 wins the first tie. The pointer updates only on grant. A lone requester always wins.
- XFER, beat k (k = 0..N-1, where N = 1 for byte mode and BEATS for word mode):
  - `mem_a_o` = latched address + k, modulo 2^ADDRESS_WIDTH (wrap-around allowed). No alignment check.
  - Store: `mem_we_o` = 1 and `mem_wd_o` = wdata[8k+7:8k].
  - Load: `mem_we_o` = 0 and `mem_rd_i` is captured into rdata byte k at the clock edge.
  - At k = N-1, go to DONE; otherwise k increments.
- DONE:
  - `ready_o[winner]` = 1.
  - `rdata_o` = assembled word. In byte mode it is the zero-extended byte with bits 31:8 = 0. For stores `rdata_o` is don't-care.
  - Next state is always IDLE.
- Requester rule: drop `req_i` in the cycle after `ready_o`. A request still high in the following IDLE is a new transaction.
- Inputs sampled only in IDLE. Requester fields may change after grant without effect.
- `mem_we_o` = 0, `mem_a_o` = 0, `mem_wd_o` = 0 outside XFER.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `ready_o` = 0, `busy_o` = 0, `mem_we_o` = 0, `mem_a_o` = 0, `mem_wd_o` = 0, `rdata_o` = 0, pointer = 1, beat counter = 0.
- Reset mid-XFER aborts the transfer. Bytes already written stay written; no `ready_o` is issued.
- Latency from request seen in IDLE (cycle 0):
  - Beats occupy cycles 1..N.
  - `ready_o` in cycle N+1.
  - IDLE again in cycle N+2.
  - Word access: `ready_o` at cycle 5. Byte access: `ready_o` at cycle 2.
- Simultaneous requests: one winner per IDLE cycle; the loser waits, keeping `req_i` high.
- Back-to-back under contention alternates ports; each port gets at most one grant per two transactions.
- `busy_o` is high from cycle 1 through cycle N+1.

## Structure
- Package `dmem_ctrl_pkg`:
  - State enum (`IDLE`, `XFER`, `DONE`).
  - Port index constants (`PORT_CPU` = 0, `PORT_LDR` = 1).
  - `BEATS` derivation.
- Sub-module `rr_arbiter2`: 2-way round-robin arbiter. Inputs are request[1:0] and a grant-accept strobe; outputs are a one-hot grant and the index.
- The FSM, beat counter, latched request registers and rdata assembly live in `dmem_ctrl`.

## Test plan
- Word store, port 0 alone: addr 0x10000, wdata 0xDEADBEEF. Expect beats at 0x10000..0x10003 writing EF, BE, AD, DE, then `ready_o` = 01 at cycle 5.
- Word load, port 1 alone: memory 0x10004..7 = 11 22 33 44. Expect `rdata_o` = 0x44332211 with `ready_o` = 10 at cycle 5.
- Byte load, port 0: addr 0x10002, byte 0xA5. Expect `rdata_o` = 0x000000A5 and `ready_o` at cycle 2, with `mem_we_o` never high.
- Both ports requesting continuously from reset: expect grant order 0,1,0,1, each `ready_o` pulse exactly one cycle and never both bits set.
- Word store at addr 0xFFFFFFFE: expect beat addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Assert `rst_n` = 0 after beat 1 of a word store: expect `mem_we_o` to drop immediately, no `ready_o`, state IDLE, and only 2 bytes modified.
